// File: rtl/spu_pkg.sv
// ----------------------------------------------------------------------------
// spu_pkg
// Shared constants and types for the SPU writeback/forwarding unit.
//   DEPTH   : writeback stages per pipe; entries retire from stage DEPTH
//   ADDR_W  : register address width
//   DATA_W  : register data width
//   STAGE_W : width of the insertion-stage field
//   NUM_RD  : number of operand read ports served by forwarding
//   wb_entry_t : one in-flight result {valid, addr, data}
// Invalid entries are always held as all-zero, so stage DEPTH can drive the
// register file write port directly without output masking.
// ----------------------------------------------------------------------------
package spu_pkg;

    localparam int DEPTH   = 7;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 128;
    localparam int STAGE_W = 3;
    localparam int NUM_RD  = 6;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    localparam wb_entry_t WB_EMPTY = '0;

    // Legal insertion stages are 1..DEPTH.
    function automatic logic stage_in_range(input logic [STAGE_W-1:0] s);
        return (s != '0) && ({1'b0, s} <= (STAGE_W+1)'(DEPTH));
    endfunction

endpackage

// File: rtl/spu_writeback_unit_if.sv
// ----------------------------------------------------------------------------
// spu_writeback_unit_if
// Bundles the execution-pipe insert ports, register file write ports, operand
// read ports and forwarding outputs of the SPU writeback unit.
//   master : execution pipes / register file side (drives inserts, read
//            addresses and register file read data)
//   slave  : the writeback unit itself
// ----------------------------------------------------------------------------
interface spu_writeback_unit_if;
    import spu_pkg::*;

    logic               flush;
    logic               ev_valid;
    logic               od_valid;
    logic [STAGE_W-1:0] ev_stage;
    logic [STAGE_W-1:0] od_stage;
    logic [ADDR_W-1:0]  ev_addr;
    logic [ADDR_W-1:0]  od_addr;
    logic [DATA_W-1:0]  ev_data;
    logic [DATA_W-1:0]  od_data;

    logic               reg_write_en_1;
    logic               reg_write_en_2;
    logic [ADDR_W-1:0]  reg_write_addr_1;
    logic [ADDR_W-1:0]  reg_write_addr_2;
    logic [DATA_W-1:0]  reg_write_data_1;
    logic [DATA_W-1:0]  reg_write_data_2;

    logic [ADDR_W-1:0]  rd_addr_1, rd_addr_2, rd_addr_3, rd_addr_4, rd_addr_5, rd_addr_6;
    logic [DATA_W-1:0]  rf_data_1, rf_data_2, rf_data_3, rf_data_4, rf_data_5, rf_data_6;
    logic [DATA_W-1:0]  fwd_data_1, fwd_data_2, fwd_data_3, fwd_data_4, fwd_data_5, fwd_data_6;

    logic               busy;
    logic               err;

    modport master (
        output flush, ev_valid, od_valid, ev_stage, od_stage,
               ev_addr, od_addr, ev_data, od_data,
               rd_addr_1, rd_addr_2, rd_addr_3, rd_addr_4, rd_addr_5, rd_addr_6,
               rf_data_1, rf_data_2, rf_data_3, rf_data_4, rf_data_5, rf_data_6,
        input  reg_write_en_1, reg_write_en_2, reg_write_addr_1, reg_write_addr_2,
               reg_write_data_1, reg_write_data_2,
               fwd_data_1, fwd_data_2, fwd_data_3, fwd_data_4, fwd_data_5, fwd_data_6,
               busy, err
    );

    modport slave (
        input  flush, ev_valid, od_valid, ev_stage, od_stage,
               ev_addr, od_addr, ev_data, od_data,
               rd_addr_1, rd_addr_2, rd_addr_3, rd_addr_4, rd_addr_5, rd_addr_6,
               rf_data_1, rf_data_2, rf_data_3, rf_data_4, rf_data_5, rf_data_6,
        output reg_write_en_1, reg_write_en_2, reg_write_addr_1, reg_write_addr_2,
               reg_write_data_1, reg_write_data_2,
               fwd_data_1, fwd_data_2, fwd_data_3, fwd_data_4, fwd_data_5, fwd_data_6,
               busy, err
    );

endinterface

// File: rtl/spu_wb_pipe.sv
// ----------------------------------------------------------------------------
// spu_wb_pipe
// One execution pipe's writeback shift register, stages 1..DEPTH.
// Every edge each entry advances one stage; stage DEPTH falls off the end
// after driving the write port. A result is inserted directly at the stage
// matching its remaining latency and replaces whatever was shifting in.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   flush      : clear all entries and drop this cycle's insert
//   ins_valid  : insert strobe
//   ins_kill   : insert suppressed by the other pipe (same stage and addr)
//   ins_stage  : insertion stage, legal 1..DEPTH
//   ins_addr   : destination register
//   ins_data   : result value
//   stages     : current entries, index = stage number
//   ins_err    : this cycle's insert is a protocol error (bad stage/override)
// ----------------------------------------------------------------------------
module spu_wb_pipe
    import spu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  ins_valid,
    input  logic                  ins_kill,
    input  logic [STAGE_W-1:0]    ins_stage,
    input  logic [ADDR_W-1:0]     ins_addr,
    input  logic [DATA_W-1:0]     ins_data,
    output wb_entry_t [DEPTH:1]   stages,
    output logic                  ins_err
);

    wb_entry_t [DEPTH:1] stg_r;
    wb_entry_t [DEPTH:1] stg_nxt_s;
    wb_entry_t           ins_entry_s;
    logic                ins_req_s;
    logic                in_range_s;
    logic                override_s;
    logic                ins_err_s;

    // Next-state: shift by one stage, then land the insert at its stage.
    always_comb begin
        ins_entry_s = '{valid: 1'b1, addr: ins_addr, data: ins_data};
        ins_req_s   = ins_valid & ~ins_kill & ~flush;
        in_range_s  = stage_in_range(ins_stage);
        override_s  = 1'b0;
        stg_nxt_s   = '0;
        // Stage 1 has no predecessor, so it always refills empty.
        for (int k = 2; k <= DEPTH; k++) begin
            stg_nxt_s[k] = flush ? WB_EMPTY : stg_r[k-1];
            override_s   = override_s | (ins_req_s & (ins_stage == STAGE_W'(k)) & stg_r[k-1].valid);
        end
        for (int k = 1; k <= DEPTH; k++) begin
            stg_nxt_s[k] = (ins_req_s && in_range_s && (ins_stage == STAGE_W'(k))) ? ins_entry_s
                                                                                   : stg_nxt_s[k];
        end
        ins_err_s = ins_req_s & (~in_range_s | override_s);
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_r <= '0;
        end else begin
            stg_r <= stg_nxt_s;
        end
    end

    assign stages  = stg_r;
    assign ins_err = ins_err_s;

endmodule

// File: rtl/spu_writeback_unit.sv
// ----------------------------------------------------------------------------
// spu_writeback_unit
// Writeback/forwarding stage for the SPU 128x128-bit register file. Even-pipe
// results retire on write port 1, odd-pipe results on write port 2, both from
// stage DEPTH of their pipe. In-flight results are bypassed to the six operand
// read ports; the youngest result (lowest stage) wins, odd beats even at an
// equal stage, otherwise the register file data passes through.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   wb       : spu_writeback_unit_if.slave (inserts, flush, write ports,
//              read ports, forwarding outputs, busy, sticky err)
// Configuration macro:
//   SPU_WB_FORWARD_EN : when defined the forwarding comparators and muxes are
//                       built; when undefined fwd_data_n = rf_data_n.
// ----------------------------------------------------------------------------
module spu_writeback_unit
    import spu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    spu_writeback_unit_if.slave  wb
);

    wb_entry_t [DEPTH:1] ev_stg_s;
    wb_entry_t [DEPTH:1] od_stg_s;
    logic                ev_err_s;
    logic                od_err_s;
    logic                collide_s;
    logic                busy_s;
    logic                err_r;
    logic [DATA_W-1:0]   fwd_s [NUM_RD];

    // Even and odd claiming the same stage for the same register: odd is kept.
    assign collide_s = wb.ev_valid & wb.od_valid &
                       (wb.ev_stage == wb.od_stage) & (wb.ev_addr == wb.od_addr);

    spu_wb_pipe u_even (
        .clk       (clk),
        .rst       (rst),
        .flush     (wb.flush),
        .ins_valid (wb.ev_valid),
        .ins_kill  (collide_s),
        .ins_stage (wb.ev_stage),
        .ins_addr  (wb.ev_addr),
        .ins_data  (wb.ev_data),
        .stages    (ev_stg_s),
        .ins_err   (ev_err_s)
    );

    spu_wb_pipe u_odd (
        .clk       (clk),
        .rst       (rst),
        .flush     (wb.flush),
        .ins_valid (wb.od_valid),
        .ins_kill  (1'b0),
        .ins_stage (wb.od_stage),
        .ins_addr  (wb.od_addr),
        .ins_data  (wb.od_data),
        .stages    (od_stg_s),
        .ins_err   (od_err_s)
    );

    // Sticky protocol error; a flushed cycle discards its inserts unjudged.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | ev_err_s | od_err_s | (collide_s & ~wb.flush);
        end
    end

    // Any valid entry in either pipe.
    always_comb begin
        busy_s = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            busy_s = busy_s | ev_stg_s[k].valid | od_stg_s[k].valid;
        end
    end

`ifdef SPU_WB_FORWARD_EN
    logic [ADDR_W-1:0] rd_s [NUM_RD];
    logic [DATA_W-1:0] rf_s [NUM_RD];

    assign rd_s = '{wb.rd_addr_1, wb.rd_addr_2, wb.rd_addr_3, wb.rd_addr_4, wb.rd_addr_5, wb.rd_addr_6};
    assign rf_s = '{wb.rf_data_1, wb.rf_data_2, wb.rf_data_3, wb.rf_data_4, wb.rf_data_5, wb.rf_data_6};

    // Bypass: walk oldest to youngest, even before odd, so the last hit is
    // the lowest stage and odd wins ties.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            fwd_s[p] = rf_s[p];
            for (int k = DEPTH; k >= 1; k--) begin
                fwd_s[p] = (ev_stg_s[k].valid && (ev_stg_s[k].addr == rd_s[p])) ? ev_stg_s[k].data : fwd_s[p];
                fwd_s[p] = (od_stg_s[k].valid && (od_stg_s[k].addr == rd_s[p])) ? od_stg_s[k].data : fwd_s[p];
            end
        end
    end
`else
    logic fwd_unused_s;

    // Forwarding disabled: register file data passes straight through.
    always_comb begin
        fwd_s[0] = wb.rf_data_1;
        fwd_s[1] = wb.rf_data_2;
        fwd_s[2] = wb.rf_data_3;
        fwd_s[3] = wb.rf_data_4;
        fwd_s[4] = wb.rf_data_5;
        fwd_s[5] = wb.rf_data_6;
    end

    assign fwd_unused_s = ^{ev_stg_s, od_stg_s, wb.rd_addr_1, wb.rd_addr_2, wb.rd_addr_3,
                            wb.rd_addr_4, wb.rd_addr_5, wb.rd_addr_6};
`endif

    // Invalid entries are all-zero, so stage DEPTH drives the ports as-is.
    assign wb.reg_write_en_1   = ev_stg_s[DEPTH].valid;
    assign wb.reg_write_addr_1 = ev_stg_s[DEPTH].addr;
    assign wb.reg_write_data_1 = ev_stg_s[DEPTH].data;
    assign wb.reg_write_en_2   = od_stg_s[DEPTH].valid;
    assign wb.reg_write_addr_2 = od_stg_s[DEPTH].addr;
    assign wb.reg_write_data_2 = od_stg_s[DEPTH].data;

    assign wb.fwd_data_1 = fwd_s[0];
    assign wb.fwd_data_2 = fwd_s[1];
    assign wb.fwd_data_3 = fwd_s[2];
    assign wb.fwd_data_4 = fwd_s[3];
    assign wb.fwd_data_5 = fwd_s[4];
    assign wb.fwd_data_6 = fwd_s[5];

    assign wb.busy = busy_s;
    assign wb.err  = err_r;

endmodule

// File: tb/tb_spu_writeback_unit.sv
// ----------------------------------------------------------------------------
// tb_spu_writeback_unit
// Self-checking bench for spu_writeback_unit. The reference model keeps a
// list of pending results, each tagged with its pipe and absolute retirement
// cycle; stage = DEPTH - (cycles left). Inputs are driven on the falling edge
// and outputs checked shortly after it. Honours SPU_WB_FORWARD_EN.
// ----------------------------------------------------------------------------
module tb_spu_writeback_unit;
    import spu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spu_writeback_unit_if wb_if ();

    spu_writeback_unit dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb_if)
    );

    typedef struct {
        bit                odd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                retire;
    } pend_t;

    pend_t pend[$];
    bit    exp_err;
    int    cyc;
    int    n_chk;
    int    n_pass;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [ADDR_W-1:0] rd_of(input int p);
        case (p)
            0: return wb_if.rd_addr_1;
            1: return wb_if.rd_addr_2;
            2: return wb_if.rd_addr_3;
            3: return wb_if.rd_addr_4;
            4: return wb_if.rd_addr_5;
            default: return wb_if.rd_addr_6;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] rf_of(input int p);
        case (p)
            0: return wb_if.rf_data_1;
            1: return wb_if.rf_data_2;
            2: return wb_if.rf_data_3;
            3: return wb_if.rf_data_4;
            4: return wb_if.rf_data_5;
            default: return wb_if.rf_data_6;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] fwd_of(input int p);
        case (p)
            0: return wb_if.fwd_data_1;
            1: return wb_if.fwd_data_2;
            2: return wb_if.fwd_data_3;
            3: return wb_if.fwd_data_4;
            4: return wb_if.fwd_data_5;
            default: return wb_if.fwd_data_6;
        endcase
    endfunction

    task automatic set_rd(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        case (p)
            0: begin wb_if.rd_addr_1 = a; wb_if.rf_data_1 = d; end
            1: begin wb_if.rd_addr_2 = a; wb_if.rf_data_2 = d; end
            2: begin wb_if.rd_addr_3 = a; wb_if.rf_data_3 = d; end
            3: begin wb_if.rd_addr_4 = a; wb_if.rf_data_4 = d; end
            4: begin wb_if.rd_addr_5 = a; wb_if.rf_data_5 = d; end
            default: begin wb_if.rd_addr_6 = a; wb_if.rf_data_6 = d; end
        endcase
    endtask

    task automatic idle();
        rst            = 1'b0;
        wb_if.flush    = 1'b0;
        wb_if.ev_valid = 1'b0;
        wb_if.od_valid = 1'b0;
        wb_if.ev_stage = 3'd0;
        wb_if.od_stage = 3'd0;
        wb_if.ev_addr  = 7'd0;
        wb_if.od_addr  = 7'd0;
        wb_if.ev_data  = 128'd0;
        wb_if.od_data  = 128'd0;
        for (int p = 0; p < NUM_RD; p++) set_rd(p, 7'd127, {4{32'hC0DE_0000 + 32'(p)}});
    endtask

    // Compare every DUT output against the pending-result list for this cycle.
    task automatic model_check();
        logic              en   [2];
        logic [ADDR_W-1:0] addr [2];
        logic [DATA_W-1:0] data [2];
        bit                busy;
        logic [DATA_W-1:0] exp_fwd;
        int                best;
        int                st;
        busy = 1'b0;
        for (int i = 0; i < 2; i++) begin en[i] = 1'b0; addr[i] = '0; data[i] = '0; end
        foreach (pend[i]) begin
            busy = 1'b1;
            if (pend[i].retire == cyc) begin
                en[pend[i].odd]   = 1'b1;
                addr[pend[i].odd] = pend[i].addr;
                data[pend[i].odd] = pend[i].data;
            end
        end
        chk("wr_en_1",   wb_if.reg_write_en_1,   en[0]);
        chk("wr_addr_1", wb_if.reg_write_addr_1, addr[0]);
        chk("wr_data_1", wb_if.reg_write_data_1, data[0]);
        chk("wr_en_2",   wb_if.reg_write_en_2,   en[1]);
        chk("wr_addr_2", wb_if.reg_write_addr_2, addr[1]);
        chk("wr_data_2", wb_if.reg_write_data_2, data[1]);
        chk("busy",      wb_if.busy,             busy);
        chk("err",       wb_if.err,              exp_err);
        for (int p = 0; p < NUM_RD; p++) begin
            exp_fwd = rf_of(p);
            best    = DEPTH + 1;
`ifdef SPU_WB_FORWARD_EN
            foreach (pend[i]) begin
                st = DEPTH - (pend[i].retire - cyc);
                if (pend[i].addr == rd_of(p) && (st < best || (st == best && pend[i].odd))) begin
                    best    = st;
                    exp_fwd = pend[i].data;
                end
            end
`endif
            chk($sformatf("fwd_data_%0d", p + 1), fwd_of(p), exp_fwd);
        end
    endtask

    task automatic model_insert(input bit odd, input int stage, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d);
        pend_t e;
        int    r;
        if (stage < 1 || stage > DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        r = cyc + 1 + DEPTH - stage;
        for (int i = 0; i < pend.size(); i++) begin
            if (pend[i].odd == odd && pend[i].retire == r) begin
                pend.delete(i);
                exp_err = 1'b1;
                break;
            end
        end
        e.odd = odd; e.addr = a; e.data = d; e.retire = r;
        pend.push_back(e);
    endtask

    // Apply the inputs sampled at the coming edge to the pending-result list.
    task automatic model_step();
        pend_t keep[$];
        bit    ev_ok;
        foreach (pend[i]) if (pend[i].retire > cyc) keep.push_back(pend[i]);
        pend = keep;
        if (rst) begin
            pend.delete();
            exp_err = 1'b0;
        end else if (wb_if.flush) begin
            pend.delete();
        end else begin
            ev_ok = wb_if.ev_valid;
            if (wb_if.ev_valid && wb_if.od_valid && wb_if.ev_stage == wb_if.od_stage &&
                wb_if.ev_addr == wb_if.od_addr) begin
                ev_ok   = 1'b0;
                exp_err = 1'b1;
            end
            if (ev_ok) model_insert(1'b0, int'(wb_if.ev_stage), wb_if.ev_addr, wb_if.ev_data);
            if (wb_if.od_valid) model_insert(1'b1, int'(wb_if.od_stage), wb_if.od_addr, wb_if.od_data);
        end
    endtask

    // Inputs are already driven (falling edge): check, advance model, next cycle.
    task automatic tick();
        #1;
        model_check();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    logic [DATA_W-1:0] dx, dy, rfv;
    int                cnt;

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; exp_err = 1'b0;
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy",  wb_if.busy,           1'b0);
        chk("rst_err",   wb_if.err,            1'b0);
        chk("rst_en_1",  wb_if.reg_write_en_1, 1'b0);
        chk("rst_en_2",  wb_if.reg_write_en_2, 1'b0);
        tick();
        idle();

        // Even stage-7 insert retires the very next cycle.
        wb_if.ev_valid = 1'b1; wb_if.ev_stage = 3'd7; wb_if.ev_addr = 7'd5; wb_if.ev_data = {32{4'hA}};
        tick();
        idle();
        chk("t1_en_1",   wb_if.reg_write_en_1,   1'b1);
        chk("t1_addr_1", wb_if.reg_write_addr_1, 7'd5);
        chk("t1_data_1", wb_if.reg_write_data_1, {32{4'hA}});
        tick();
        chk("t1_en_1_off", wb_if.reg_write_en_1, 1'b0);
        chk("t1_busy_off", wb_if.busy,           1'b0);

        // Odd stage-2 insert forwarded for six cycles, then written.
        dx = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        rfv = {4{32'h5555_AAAA}};
        wb_if.od_valid = 1'b1; wb_if.od_stage = 3'd2; wb_if.od_addr = 7'd9; wb_if.od_data = dx;
        set_rd(2, 7'd9, rfv);
        #1 chk("t2_fwd3_ins_cycle", wb_if.fwd_data_3, rfv);
        tick();
        for (int i = 1; i <= 6; i++) begin
            idle();
            set_rd(2, 7'd9, rfv);
`ifdef SPU_WB_FORWARD_EN
            #1 chk($sformatf("t2_fwd3_c%0d", i), wb_if.fwd_data_3, dx);
`else
            #1 chk($sformatf("t2_fwd3_c%0d", i), wb_if.fwd_data_3, rfv);
`endif
            chk($sformatf("t2_en_2_c%0d", i), wb_if.reg_write_en_2, (i == 6) ? 1'b1 : 1'b0);
            tick();
        end
        idle();
        set_rd(2, 7'd9, rfv);
        #1 chk("t2_fwd3_after", wb_if.fwd_data_3, rfv);

        // Odd stage 2 X, then even stage 6 Y to the same register.
        dy = {4{32'hDEAD_BEEF}};
        wb_if.od_valid = 1'b1; wb_if.od_stage = 3'd2; wb_if.od_addr = 7'd3; wb_if.od_data = dx;
        tick();
        idle();
        wb_if.ev_valid = 1'b1; wb_if.ev_stage = 3'd6; wb_if.ev_addr = 7'd3; wb_if.ev_data = dy;
        tick();
        idle();
        set_rd(0, 7'd3, rfv);
`ifdef SPU_WB_FORWARD_EN
        #1 chk("t3_fwd1", wb_if.fwd_data_1, dx);
`else
        #1 chk("t3_fwd1", wb_if.fwd_data_1, rfv);
`endif
        tick();
        idle();
        chk("t3_even_first", wb_if.reg_write_data_1, dy);
        chk("t3_odd_not_yet", wb_if.reg_write_en_2, 1'b0);
        tick(); tick(); tick();
        chk("t3_odd_later", wb_if.reg_write_data_2, dx);
        tick();

        // Override: second even insert replaces the first.
        wb_if.ev_valid = 1'b1; wb_if.ev_stage = 3'd3; wb_if.ev_addr = 7'd1; wb_if.ev_data = dx;
        tick();
        idle();
        chk("t4_err_before", wb_if.err, 1'b0);
        wb_if.ev_valid = 1'b1; wb_if.ev_stage = 3'd4; wb_if.ev_addr = 7'd1; wb_if.ev_data = dy;
        tick();
        idle();
        chk("t4_err_set", wb_if.err, 1'b1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (wb_if.reg_write_en_1 === 1'b1) begin
                cnt++;
                chk("t4_data", wb_if.reg_write_data_1, dy);
            end
            tick();
        end
        chk("t4_writes", 32'(cnt), 32'd1);
        chk("t4_err_sticky", wb_if.err, 1'b1);

        // Flush with entries in stages 7 (even) and 2 (odd).
        wb_if.ev_valid = 1'b1; wb_if.ev_stage = 3'd7; wb_if.ev_addr = 7'd2; wb_if.ev_data = dx;
        wb_if.od_valid = 1'b1; wb_if.od_stage = 3'd2; wb_if.od_addr = 7'd4; wb_if.od_data = dy;
        tick();
        idle();
        wb_if.flush = 1'b1;
        chk("t5_flush_write", wb_if.reg_write_en_1, 1'b1);
        tick();
        idle();
        chk("t5_busy_off", wb_if.busy, 1'b0);
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            cnt += int'(wb_if.reg_write_en_1) + int'(wb_if.reg_write_en_2);
            tick();
        end
        chk("t5_no_writes", 32'(cnt), 32'd0);

        // Reset with four entries in flight.
        wb_if.ev_valid = 1'b1; wb_if.ev_stage = 3'd5; wb_if.ev_addr = 7'd6; wb_if.ev_data = dx;
        wb_if.od_valid = 1'b1; wb_if.od_stage = 3'd4; wb_if.od_addr = 7'd7; wb_if.od_data = dy;
        tick();
        idle();
        wb_if.ev_valid = 1'b1; wb_if.ev_stage = 3'd2; wb_if.ev_addr = 7'd8; wb_if.ev_data = dy;
        wb_if.od_valid = 1'b1; wb_if.od_stage = 3'd6; wb_if.od_addr = 7'd9; wb_if.od_data = dx;
        tick();
        idle();
        rst = 1'b1;
        tick();
        idle();
        chk("t6_en_1",   wb_if.reg_write_en_1,   1'b0);
        chk("t6_en_2",   wb_if.reg_write_en_2,   1'b0);
        chk("t6_addr_1", wb_if.reg_write_addr_1, 7'd0);
        chk("t6_data_2", wb_if.reg_write_data_2, 128'd0);
        chk("t6_busy",   wb_if.busy,             1'b0);
        chk("t6_err",    wb_if.err,              1'b0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cnt += int'(wb_if.reg_write_en_1) + int'(wb_if.reg_write_en_2);
            tick();
        end
        chk("t6_no_writes", 32'(cnt), 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            idle();
            rst            = ($urandom_range(0, 99) == 0);
            wb_if.flush    = ($urandom_range(0, 39) == 0);
            wb_if.ev_valid = $urandom_range(0, 1) == 1;
            wb_if.od_valid = $urandom_range(0, 1) == 1;
            wb_if.ev_stage = ($urandom_range(0, 19) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            wb_if.od_stage = ($urandom_range(0, 19) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            wb_if.ev_addr  = 7'($urandom_range(0, 7));
            wb_if.od_addr  = 7'($urandom_range(0, 7));
            wb_if.ev_data  = rnd_data();
            wb_if.od_data  = rnd_data();
            if ($urandom_range(0, 9) == 0) begin
                wb_if.od_stage = wb_if.ev_stage;
                wb_if.od_addr  = wb_if.ev_addr;
            end
            for (int p = 0; p < NUM_RD; p++) set_rd(p, 7'($urandom_range(0, 8)), rnd_data());
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
